// File: rtl/mdu_ctrl.sv
// mdu_ctrl: execute-stage multiply/divide controller for the five-stage MIPS
// pipeline. Starts MULT/MULTU/DIV/DIVU from E, holds the unit busy for a
// fixed number of cycles, then commits the 64-bit result to the architectural
// HI/LO registers. MTHI/MTLO write HI/LO directly when the unit is idle.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   E_MDop    E-stage MD op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//             5 MTHI, 6 MTLO, 7..15 NONE
//   E_A/E_B   forwarded rs/rt operands
//   D_MDuse   D-stage instruction is MD-class
//   E_start   operation accepted this cycle (combinational)
//   E_busy    operation in flight
//   E_HI/E_LO architectural HI/LO
//   MD_stall  freeze PC/D and bubble E (combinational)
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_MDuse,
    output logic        E_start,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic        MD_stall
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_md;
    logic        w_start;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div0;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvsr_s;
    logic [31:0] w_dvsr_u;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_we;

    assign w_is_md  = (E_MDop >= OP_MULT) && (E_MDop <= OP_DIVU);
    assign w_start  = w_is_md && (r_state == S_IDLE);
    assign E_start  = w_start;
    assign E_busy   = (r_state == S_BUSY);
    assign MD_stall = D_MDuse & (w_start | E_busy);
    assign E_HI     = r_hi;
    assign E_LO     = r_lo;

    // The low 64 bits of a product of sign-extended operands equal the
    // signed 32x32 product.
    assign w_prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign w_prod_u = {32'b0, E_A} * {32'b0, E_B};

    // Signed divide on magnitudes; 0x80000000 is its own magnitude as an
    // unsigned value, which makes 0x80000000 / -1 come out as 0x80000000 r 0.
    // A zero divisor is replaced by 1 so the datapath stays defined; the
    // result is discarded at commit.
    assign w_div0   = (E_B == '0);
    assign w_mag_a  = E_A[31] ? -E_A : E_A;
    assign w_mag_b  = E_B[31] ? -E_B : E_B;
    assign w_dvsr_s = w_div0 ? 32'd1 : w_mag_b;
    assign w_dvsr_u = w_div0 ? 32'd1 : E_B;
    assign w_q_mag  = w_mag_a / w_dvsr_s;
    assign w_r_mag  = w_mag_a % w_dvsr_s;
    assign w_q_s    = (E_A[31] ^ E_B[31]) ? -w_q_mag : w_q_mag;
    assign w_r_s    = E_A[31] ? -w_r_mag : w_r_mag;
    assign w_q_u    = E_A / w_dvsr_u;
    assign w_r_u    = E_A % w_dvsr_u;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_we = 1'b0;
        case (E_MDop)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_we = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_we = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
                w_res_we = !w_div0;
            end
            OP_DIVU: begin
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
                w_res_we = !w_div0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_we <= w_res_we;
                        r_cnt     <= (E_MDop <= OP_MULTU) ? 5'(MULT_CYCLES)
                                                          : 5'(DIV_CYCLES);
                        r_state   <= S_BUSY;
                    end else if (E_MDop == OP_MTHI) begin
                        r_hi <= E_A;
                    end else if (E_MDop == OP_MTLO) begin
                        r_lo <= E_A;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        if (r_pend_we) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
